hermes_tx_monitor: RTL and testbench
====================================

Name: hermes_tx_monitor

Overview:
- Passive traffic monitor on the Hermes output link between the DMNI and the router local input port.
- Snoops each accepted flit and delineates packets using EOP.
- For each packet, records the header flit, flit count, and start/end tick into a small record FIFO.
- The CPU drains the FIFO through a word-addressed MMR port and is interrupted while records are pending. The monitor never drives the link.

Parameters:
- FLIT_SIZE, 32, Hermes flit width; must be >= 16.
- FIFO_DEPTH, 4, record FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- tick_counter_i  in  32  free-running global tick
- noc_tx_i  in  1  link valid (DMNI noc_tx_o)
- noc_eop_i  in  1  last flit of packet
- noc_credit_i  in  1  router credit (ready)
- noc_data_i  in  FLIT_SIZE  flit
- cfg_en_i  in  1  MMR access strobe
- cfg_we_i  in  4  byte write enables; any nonzero value is a full-word write
- cfg_addr_i  in  3  word address
- cfg_data_i  in  32  write data
- cfg_data_o  out  32  read data, registered
- irq_o  out  1  record pending, registered
- overflow_o  out  1  sticky drop flag

Behaviour:
- Flit transfer: noc_tx_i && noc_credit_i in the same cycle. No other signal qualifies a flit.
- FSM states: IDLE, PAYLOAD.
- IDLE, on transfer:
  - Latch hdr = noc_data_i. If FLIT_SIZE < 32, zero-extend to 32; if larger, keep the low 32 bits.
  - Latch start = tick_counter_i, cnt = 1, en_snap = CTRL.enable.
  - If eop is set on the same flit: commit now (end = start) and stay in IDLE. Otherwise go to PAYLOAD.
- PAYLOAD, on transfer:
  - cnt += 1, saturating at 16'hFFFF.
  - If eop is set: commit with end = tick_counter_i, then go to IDLE.
- Commit when en_snap is 1:
  - If FIFO is not full: push {hdr, start, end, cnt}.
  - If FIFO is full: drop the record, set overflow, and increment drop_cnt (16 bits, saturating).
- Commit when en_snap is 0: discard the record. The FSM always tracks packets regardless of enable, so it stays aligned to packet boundaries.
- Commit and POP in the same cycle: the pop is applied first, so a full FIFO accepts the record with no drop.
- MMR reads:
  - Issued when cfg_en_i=1 and cfg_we_i=0. cfg_data_o is valid the next cycle and holds its value otherwise.
  - 0 STATUS: [0] valid (FIFO not empty), [1] overflow, [7:4] occupancy, [31:16] drop_cnt.
  - 1 HEADER, 2 START, 3 END, 4 COUNT ([15:0] cnt, upper bits 0): fields of the head record; all read 0 when the FIFO is empty.
  - 6 CTRL: [0] enable.
  - 7: see Optional Feature.
  - Address 5 and any unmapped address read 0.
- MMR writes:
  - 5 POP: any data pops the head record; ignored when the FIFO is empty.
  - 6 CTRL: [0] enable; writing [1]=1 clears overflow and drop_cnt. Bit [1] self-clears and reads 0.
  - Writes to all other addresses are ignored.
- irq_o: registered copy of FIFO not-empty, one cycle after the push/pop that changes it.
- overflow_o: mirrors the overflow flag.
- Reset (sync, rst_i=1):
  - FSM to IDLE; FIFO empty; cnt, overflow, drop_cnt cleared.
  - enable = 1.
  - cfg_data_o = 0, irq_o = 0, overflow_o = 0.
  - A packet in flight at reset is forgotten; its remaining flits are treated as a new packet starting at the next flit.
- Pointers are log2(FIFO_DEPTH)+1 bits wide so full and empty are distinguished; they wrap naturally.

Optional Feature:
- Macro HERMES_TX_MONITOR_CHECKSUM_EN.
- When defined:
  - Each record also stores a 32-bit XOR of all flits of the packet, header included, each zero-extended or truncated to 32 bits.
  - Address 7 reads the head record's checksum.
- When undefined: no checksum storage; address 7 reads 0.

Test Plan:
- Packet of 3 flits (0x00000102, 0x5, 0xA, eop on the last), credit always 1, ticks 100..102 → HEADER=0x102, START=100, END=102, COUNT=3, irq_o=1; after POP, STATUS[0]=0 and irq_o falls.
- Single-flit packet with eop on flit 0 at tick 50 → START=END=50, COUNT=1.
- Credit held 0 for 2 cycles mid-packet with tx=1 → stalled cycles are not counted; COUNT equals the number of accepted flits.
- FIFO_DEPTH+2 packets sent, no pops → occupancy=FIFO_DEPTH, overflow_o=1, drop_cnt=2; CTRL write 0x2 → both clear, records retained.
- CTRL.enable=0 during the header of packet A and enable=1 before packet B → only B is recorded; an enable toggle mid-packet does not change A's outcome.
- With the macro defined: flits 0x1, 0x2, 0x4 → address 7 reads 0x7. Without the macro: address 7 reads 0.

Source files
------------

// File: rtl/hermes_tx_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : hermes_tx_monitor
//  Purpose  : Passive monitor on the Hermes DMNI -> router local link. Every
//             accepted flit (noc_tx_i && noc_credit_i) is snooped, and EOP
//             marks the end of a packet. One record per packet goes into a
//             small FIFO: header flit, flit count and start/end tick. The CPU
//             drains the FIFO through a word-addressed MMR port. irq_o stays
//             high while records are pending. The monitor never drives the
//             link.
//
//  Ports    : clk_i, rst_i            clock, synchronous active-high reset
//             tick_counter_i         free-running global tick
//             noc_tx_i/eop_i/credit_i/data_i   snooped link
//             cfg_en_i/we_i/addr_i/data_i      MMR access (word address)
//             cfg_data_o             registered read data
//             irq_o                  registered "record pending"
//             overflow_o             sticky record-drop flag
//
//  Map      : 0 STATUS  1 HEADER  2 START  3 END  4 COUNT  5 POP(w)
//             6 CTRL    7 CHECKSUM (0 unless the checksum build is selected)
//
//  Option   : `define HERMES_TX_MONITOR_CHECKSUM_EN adds a per-record 32-bit
//             XOR of all flits, readable at address 7.
//
//  Revision : 1.0  initial release
// ============================================================================
module hermes_tx_monitor #(
    parameter int FLIT_SIZE  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          tick_counter_i,
    input  logic                 noc_tx_i,
    input  logic                 noc_eop_i,
    input  logic                 noc_credit_i,
    input  logic [FLIT_SIZE-1:0] noc_data_i,
    input  logic                 cfg_en_i,
    input  logic [3:0]           cfg_we_i,
    input  logic [2:0]           cfg_addr_i,
    input  logic [31:0]          cfg_data_i,
    output logic [31:0]          cfg_data_o,
    output logic                 irq_o,
    output logic                 overflow_o
);

    localparam int c_idx_w = $clog2(FIFO_DEPTH);
    localparam int c_ptr_w = c_idx_w + 1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    logic [31:0] w_flit32;
    logic        w_xfer;

    // In-flight packet fields
    logic [31:0] r_hdr, r_start;
    logic [15:0] r_cnt;
    logic        r_en_snap;
    logic        r_enable;

    // Record candidate presented to the FIFO on a commit
    logic        w_commit;
    logic [31:0] w_rec_hdr, w_rec_start;
    logic [15:0] w_rec_cnt, w_cnt_inc;
    logic        w_rec_en;

    // Record FIFO
    logic [31:0] r_mem_hdr   [FIFO_DEPTH];
    logic [31:0] r_mem_start [FIFO_DEPTH];
    logic [31:0] r_mem_end   [FIFO_DEPTH];
    logic [15:0] r_mem_cnt   [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr, w_count;
    logic [c_idx_w-1:0] w_wr_idx, w_head;
    logic               w_empty, w_full;

`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
    logic [31:0] r_csum, w_rec_csum;
    logic [31:0] r_mem_csum [FIFO_DEPTH];
`endif

    logic        r_overflow;
    logic [15:0] r_drop_cnt;
    logic [31:0] r_cfg_data, w_rd_data;
    logic        r_irq;

    logic w_cfg_rd, w_cfg_wr, w_pop, w_ctrl_wr, w_rec_keep, w_push, w_drop;
    logic w_unused;

    // Flits are zero-extended or truncated to a 32-bit record word
    generate
        if (FLIT_SIZE >= 32) begin : g_flit_trunc
            assign w_flit32 = noc_data_i[31:0];
        end else begin : g_flit_zext
            assign w_flit32 = {{(32 - FLIT_SIZE){1'b0}}, noc_data_i};
        end
    endgenerate

    assign w_xfer    = noc_tx_i && noc_credit_i;
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    // ---------------- packet delineation FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_rec_hdr   = r_hdr;
        w_rec_start = r_start;
        w_rec_cnt   = r_cnt;
        w_rec_en    = r_en_snap;
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
        w_rec_csum  = r_csum ^ w_flit32;
`endif
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_rec_hdr   = w_flit32;
                    w_rec_start = tick_counter_i;
                    w_rec_cnt   = 16'd1;
                    w_rec_en    = r_enable;
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
                    w_rec_csum  = w_flit32;
`endif
                    if (noc_eop_i) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (w_xfer) begin
                    w_rec_cnt = w_cnt_inc;
                    if (noc_eop_i) begin
                        w_commit    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Packet fields follow the candidate on every accepted flit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hdr     <= 32'd0;
            r_start   <= 32'd0;
            r_cnt     <= 16'd0;
            r_en_snap <= 1'b0;
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
            r_csum    <= 32'd0;
`endif
        end else if (w_xfer) begin
            r_hdr     <= w_rec_hdr;
            r_start   <= w_rec_start;
            r_cnt     <= w_rec_cnt;
            r_en_snap <= w_rec_en;
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
            r_csum    <= w_rec_csum;
`endif
        end
    end

    // ---------------- record FIFO ----------------
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_count == c_ptr_w'(FIFO_DEPTH));
    assign w_wr_idx = r_wr_ptr[c_idx_w-1:0];
    assign w_head   = r_rd_ptr[c_idx_w-1:0];

    assign w_cfg_rd   = cfg_en_i && (cfg_we_i == 4'd0);
    assign w_cfg_wr   = cfg_en_i && (cfg_we_i != 4'd0);
    assign w_pop      = w_cfg_wr && (cfg_addr_i == 3'd5) && !w_empty;
    assign w_ctrl_wr  = w_cfg_wr && (cfg_addr_i == 3'd6);
    assign w_rec_keep = w_commit && w_rec_en;
    // A same-cycle pop frees a slot before the commit is considered
    assign w_push     = w_rec_keep && (!w_full || w_pop);
    assign w_drop     = w_rec_keep && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_hdr[w_wr_idx]   <= w_rec_hdr;
            r_mem_start[w_wr_idx] <= w_rec_start;
            r_mem_end[w_wr_idx]   <= tick_counter_i;
            r_mem_cnt[w_wr_idx]   <= w_rec_cnt;
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
            r_mem_csum[w_wr_idx]  <= w_rec_csum;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- control / status ----------------
    // A clear request wins over a drop in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_enable   <= 1'b1;
            r_overflow <= 1'b0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_ctrl_wr) r_enable <= cfg_data_i[0];
            if (w_ctrl_wr && cfg_data_i[1]) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= 16'd0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_rd_data = 32'd0;
        case (cfg_addr_i)
            3'd0: w_rd_data = {r_drop_cnt, 8'd0, 4'(w_count), 2'b00, r_overflow, !w_empty};
            3'd1: if (!w_empty) w_rd_data = r_mem_hdr[w_head];
            3'd2: if (!w_empty) w_rd_data = r_mem_start[w_head];
            3'd3: if (!w_empty) w_rd_data = r_mem_end[w_head];
            3'd4: if (!w_empty) w_rd_data = {16'd0, r_mem_cnt[w_head]};
            3'd6: w_rd_data = {31'd0, r_enable};
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
            3'd7: if (!w_empty) w_rd_data = r_mem_csum[w_head];
`endif
            default: w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cfg_data <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            if (w_cfg_rd) r_cfg_data <= w_rd_data;
            r_irq <= !w_empty;
        end
    end

    assign cfg_data_o = r_cfg_data;
    assign irq_o      = r_irq;
    assign overflow_o = r_overflow;

    // Only CTRL bits [1:0] carry meaning on writes
    assign w_unused = ^cfg_data_i[31:2];

endmodule
`default_nettype wire

// File: tb/tb_hermes_tx_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hermes_tx_monitor
//  Purpose  : Self-checking bench for hermes_tx_monitor. A queue-based
//             reference model predicts cfg_data_o, irq_o and overflow_o for
//             every cycle. Directed reads pin the model to literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hermes_tx_monitor;

    localparam int FLIT_SIZE  = 32;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tick_counter;
    logic        noc_tx, noc_eop, noc_credit;
    logic [31:0] noc_data;
    logic        cfg_en;
    logic [3:0]  cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_data;
    logic        irq, overflow;

    always #5 clk = ~clk;

    hermes_tx_monitor #(.FLIT_SIZE(FLIT_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tick_counter_i (tick_counter),
        .noc_tx_i       (noc_tx),
        .noc_eop_i      (noc_eop),
        .noc_credit_i   (noc_credit),
        .noc_data_i     (noc_data),
        .cfg_en_i       (cfg_en),
        .cfg_we_i       (cfg_we),
        .cfg_addr_i     (cfg_addr),
        .cfg_data_i     (cfg_wdata),
        .cfg_data_o     (cfg_data),
        .irq_o          (irq),
        .overflow_o     (overflow)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit [31:0] hdr;
        bit [31:0] start;
        bit [31:0] stop;
        bit [15:0] cnt;
        bit [31:0] cs;
        bit        en;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    bit   in_pkt;
    bit   m_enable;
    bit   m_ovf;
    int   m_drop;

    logic [31:0] n_cfg, exp_cfg;
    logic        n_irq, exp_irq, n_ovf, exp_ovf;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        bit [15:0] d;
        d = m_drop[15:0];
        case (a)
            3'd0: return {d, 8'd0, 4'(q.size()), 2'b00, m_ovf, q.size() != 0};
            3'd1: return (q.size() == 0) ? 32'd0 : q[0].hdr;
            3'd2: return (q.size() == 0) ? 32'd0 : q[0].start;
            3'd3: return (q.size() == 0) ? 32'd0 : q[0].stop;
            3'd4: return (q.size() == 0) ? 32'd0 : {16'd0, q[0].cnt};
            3'd6: return {31'd0, m_enable};
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
            3'd7: return (q.size() == 0) ? 32'd0 : q[0].cs;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Predict the outputs that follow the coming clock edge
    task automatic model_step();
        bit fin;
        bit cur_irq;
        if (rst) begin
            q.delete();
            in_pkt   = 0;
            m_enable = 1;
            m_ovf    = 0;
            m_drop   = 0;
            n_cfg    = 32'd0;
            n_irq    = 1'b0;
            n_ovf    = 1'b0;
            return;
        end
        cur_irq = (q.size() != 0);
        if (cfg_en && cfg_we == 4'd0) n_cfg = model_read(cfg_addr);
        fin = 0;
        if (noc_tx && noc_credit) begin
            if (!in_pkt) begin
                cur.hdr   = noc_data;
                cur.start = tick_counter;
                cur.cnt   = 16'd1;
                cur.en    = m_enable;
                cur.cs    = noc_data;
            end else begin
                if (cur.cnt != 16'hFFFF) cur.cnt = cur.cnt + 16'd1;
                cur.cs = cur.cs ^ noc_data;
            end
            if (noc_eop) begin
                cur.stop = tick_counter;
                fin      = 1;
                in_pkt   = 0;
            end else begin
                in_pkt = 1;
            end
        end
        if (cfg_en && cfg_we != 4'd0 && cfg_addr == 3'd5 && q.size() > 0)
            void'(q.pop_front());
        if (fin && cur.en) begin
            if (q.size() < FIFO_DEPTH) begin
                q.push_back(cur);
            end else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop = m_drop + 1;
            end
        end
        if (cfg_en && cfg_we != 4'd0 && cfg_addr == 3'd6) begin
            m_enable = cfg_wdata[0];
            if (cfg_wdata[1]) begin
                m_ovf  = 0;
                m_drop = 0;
            end
        end
        n_irq = cur_irq;
        n_ovf = m_ovf;
    endtask

    // One clock: predict, let the edge pass, publish the prediction
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        exp_cfg      = n_cfg;
        exp_irq      = n_irq;
        exp_ovf      = n_ovf;
        tick_counter = tick_counter + 32'd1;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            checks = checks + 1;
            if (cfg_data !== exp_cfg) begin
                errors = errors + 1;
                $display("FAIL cfg_data_o got=%h want=%h t=%0t", cfg_data, exp_cfg, $time);
            end
            checks = checks + 1;
            if (irq !== exp_irq) begin
                errors = errors + 1;
                $display("FAIL irq_o got=%b want=%b t=%0t", irq, exp_irq, $time);
            end
            checks = checks + 1;
            if (overflow !== exp_ovf) begin
                errors = errors + 1;
                $display("FAIL overflow_o got=%b want=%b t=%0t", overflow, exp_ovf, $time);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        cfg_en   = 1'b1;
        cfg_we   = 4'd0;
        cfg_addr = a;
        tick();
        cfg_en   = 1'b0;
        v        = cfg_data;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_en    = 1'b1;
        cfg_we    = 4'hF;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_en    = 1'b0;
        cfg_we    = 4'd0;
    endtask

    task automatic flit(input logic [31:0] d, input logic eop);
        noc_tx     = 1'b1;
        noc_credit = 1'b1;
        noc_data   = d;
        noc_eop    = eop;
        tick();
        noc_tx     = 1'b0;
        noc_eop    = 1'b0;
    endtask

    logic [31:0] v;
    logic [31:0] exp_cs;

    initial begin
        rst = 1'b1; tick_counter = 32'd0;
        noc_tx = 0; noc_eop = 0; noc_credit = 0; noc_data = 32'd0;
        cfg_en = 0; cfg_we = 4'd0; cfg_addr = 3'd0; cfg_wdata = 32'd0;
        tick();
        chk_on = 1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check_lit("reset_irq", {31'd0, irq}, 32'd0);
        check_lit("reset_ovf", {31'd0, overflow}, 32'd0);
        rd(3'd0, v); check_lit("reset_status", v, 32'd0);
        rd(3'd6, v); check_lit("reset_ctrl", v, 32'd1);

        // Three-flit packet at ticks 100..102
        tick_counter = 32'd100;
        flit(32'h102, 0); flit(32'h5, 0); flit(32'hA, 1);
        rd(3'd1, v); check_lit("hdr3", v, 32'h102);
        check_lit("irq_set", {31'd0, irq}, 32'd1);
        rd(3'd2, v); check_lit("start3", v, 32'd100);
        rd(3'd3, v); check_lit("end3", v, 32'd102);
        rd(3'd4, v); check_lit("count3", v, 32'd3);
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
        exp_cs = 32'h10D;
`else
        exp_cs = 32'd0;
`endif
        rd(3'd7, v); check_lit("csum3", v, exp_cs);
        wr(3'd5, 32'd0);
        rd(3'd0, v); check_lit("status_after_pop", v, 32'd0);
        check_lit("irq_fall", {31'd0, irq}, 32'd0);

        // Single-flit packet at tick 50
        tick_counter = 32'd50;
        flit(32'h77, 1);
        rd(3'd2, v); check_lit("start1", v, 32'd50);
        rd(3'd3, v); check_lit("end1", v, 32'd50);
        rd(3'd4, v); check_lit("count1", v, 32'd1);
        wr(3'd5, 32'd1);

        // Credit stall mid-packet
        flit(32'h300, 0);
        noc_tx = 1; noc_credit = 0; noc_data = 32'hDEAD; tick(); tick();
        noc_tx = 0;
        flit(32'h301, 0); flit(32'h302, 1);
        rd(3'd4, v); check_lit("count_stall", v, 32'd3);
        wr(3'd5, 32'd1);

        // Overflow: FIFO_DEPTH + 2 packets, no pops
        for (int i = 0; i < FIFO_DEPTH + 2; i++) flit(32'h200 + 32'(i), 1);
        rd(3'd0, v); check_lit("status_ovf", v, 32'h0002_0043);
        check_lit("ovf_pin", {31'd0, overflow}, 32'd1);
        wr(3'd6, 32'h3);
        rd(3'd0, v); check_lit("status_clr", v, 32'h0000_0041);
        check_lit("ovf_pin_clr", {31'd0, overflow}, 32'd0);
        rd(3'd6, v); check_lit("ctrl_selfclr", v, 32'd1);
        rd(3'd1, v); check_lit("hdr_retained", v, 32'h200);
        for (int i = 0; i < FIFO_DEPTH; i++) wr(3'd5, 32'd0);

        // Enable snapshot taken at the header
        wr(3'd6, 32'd0);
        flit(32'hA0, 0);
        wr(3'd6, 32'd1);
        flit(32'hA1, 0); flit(32'hA2, 1);
        flit(32'hBB, 1);
        rd(3'd0, v); check_lit("status_en", v, 32'h11);
        rd(3'd1, v); check_lit("hdr_b", v, 32'hBB);
        flit(32'hC0, 0);
        wr(3'd6, 32'd0);
        flit(32'hC1, 1);
        wr(3'd6, 32'd1);
        wr(3'd5, 32'd0);
        rd(3'd1, v); check_lit("hdr_c", v, 32'hC0);
        rd(3'd4, v); check_lit("count_c", v, 32'd2);
        wr(3'd5, 32'd0);

        // Checksum
        flit(32'h1, 0); flit(32'h2, 0); flit(32'h4, 1);
`ifdef HERMES_TX_MONITOR_CHECKSUM_EN
        exp_cs = 32'h7;
`else
        exp_cs = 32'd0;
`endif
        rd(3'd7, v); check_lit("csum124", v, exp_cs);
        rd(3'd5, v); check_lit("addr5_reads0", v, 32'd0);
        wr(3'd5, 32'd0);

        // Randomized traffic and register activity
        for (int i = 0; i < 4000; i++) begin
            int r;
            rst        = (i >= 2000 && i < 2002);
            noc_tx     = ($urandom % 4) != 0;
            noc_credit = ($urandom % 3) != 0;
            noc_eop    = ($urandom % 4) == 0;
            noc_data   = $urandom;
            r          = int'($urandom % 16);
            cfg_en     = 1'b0;
            cfg_we     = 4'd0;
            cfg_addr   = 3'($urandom % 8);
            cfg_wdata  = $urandom;
            if (r < 4) begin
                cfg_en = 1'b1;
            end else if (r < 7) begin
                cfg_en   = 1'b1;
                cfg_we   = 4'($urandom_range(1, 15));
                cfg_addr = 3'd5;
            end else if (r == 7) begin
                cfg_en    = 1'b1;
                cfg_we    = 4'($urandom_range(1, 15));
                cfg_addr  = 3'd6;
                cfg_wdata = {30'($urandom), ($urandom % 8) == 0, ($urandom % 5) != 0};
            end else if (r == 8) begin
                cfg_en   = 1'b1;
                cfg_we   = 4'($urandom_range(1, 15));
                cfg_addr = (cfg_addr == 3'd5 || cfg_addr == 3'd6) ? 3'd7 : cfg_addr;
            end
            tick();
        end
        rst = 1'b0; cfg_en = 1'b0; cfg_we = 4'd0; noc_tx = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
